// File: rtl/aes_enc_iter_if.sv
// Handshake/data bundle between an AES-128 round-iterative encryptor and its client.
// The master side drives the request and key schedule, and the slave side returns the result.
interface aes_enc_iter_if;
    logic           start;
    logic [127:0]   plaintext;
    logic [1407:0]  rkeys;
    logic [127:0]   ciphertext;
    logic           busy;
    logic           done;

    modport master (
        output start, plaintext, rkeys,
        input  ciphertext, busy, done
    );

    modport slave (
        input  start, plaintext, rkeys,
        output ciphertext, busy, done
    );
endinterface

// File: rtl/aes_enc_iter.sv
// AES-128 encryptor: one shared combinational round reused over 10 cycles.
// Also contains sbox1, the byte S-box (GF(2^8) inverse followed by the affine map).
module sbox1 (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [7:0] INV_EXP = 8'hFE;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    logic [7:0] inv;

    // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
    always_comb begin
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (INV_EXP[i]) inv = gmul(inv, din);
        end
        dout = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
endmodule

module aes_enc_iter (
    input  logic          clk,
    input  logic          rst_n,
    aes_enc_iter_if.slave bus
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_q, state_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   st_q, st_d;
    logic [127:0]   ciphertext_q, ciphertext_d;
    logic           done_q, done_d;

    logic [127:0]   rk [0:15];
    logic [7:0]     sb [0:15];
    logic [7:0]     sr [0:15];
    logic [127:0]   sr_flat;
    logic [127:0]   mc_flat;
    logic [127:0]   round_key;
    logic [127:0]   round_out;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Slots 11..15 are zero so any 4-bit rnd selects something defined.
    for (genvar gi = 0; gi < 16; gi++) begin : g_rk
        if (gi <= 10) begin : g_key
            assign rk[gi] = bus.rkeys[1407 - 128*gi -: 128];
        end else begin : g_pad
            assign rk[gi] = '0;
        end
    end

    // Byte index gi = 4*column + row; ShiftRows takes row r from column c+r.
    for (genvar gi = 0; gi < 16; gi++) begin : g_byte
        sbox1 u_sbox (
            .din  (st_q[127 - 8*gi -: 8]),
            .dout (sb[gi])
        );
        assign sr[gi] = sb[4*(((gi/4) + (gi%4)) % 4) + (gi%4)];
        assign sr_flat[127 - 8*gi -: 8] = sr[gi];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_mix
        logic [7:0] a0, a1, a2, a3;
        assign a0 = sr[4*gi];
        assign a1 = sr[4*gi + 1];
        assign a2 = sr[4*gi + 2];
        assign a3 = sr[4*gi + 3];
        assign mc_flat[127 - 32*gi -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

    assign round_key = rk[rnd_q];
    assign round_out = ((rnd_q == 4'd10) ? sr_flat : mc_flat) ^ round_key;

    always_comb begin
        state_d      = state_q;
        rnd_d        = rnd_q;
        st_d         = st_q;
        ciphertext_d = ciphertext_q;
        done_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    st_d    = bus.plaintext ^ rk[0];
                    rnd_d   = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (rnd_q >= 4'd1 && rnd_q <= 4'd9) begin
                    st_d  = round_out;
                    rnd_d = rnd_q + 4'd1;
                end else if (rnd_q == 4'd10) begin
                    st_d         = round_out;
                    ciphertext_d = round_out;
                    done_d       = 1'b1;
                    rnd_d        = 4'd0;
                    state_d      = IDLE;
                end else begin
                    // Corrupted counter: abandon the block rather than emit garbage.
                    rnd_d   = 4'd0;
                    state_d = IDLE;
                end
            end
            default: begin
                rnd_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rnd_q        <= 4'd0;
            st_q         <= '0;
            ciphertext_q <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            st_q         <= st_d;
            ciphertext_q <= ciphertext_d;
            done_q       <= done_d;
        end
    end

    assign bus.ciphertext = ciphertext_q;
    assign bus.busy       = (state_q == RUN);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed-vector bench for aes_enc_iter using FIPS-197 known-answer vectors and
// their published round-key schedules.
module tb_aes_enc_iter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    aes_enc_iter_if bus();
    aes_enc_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk = 0;
    int n_err = 0;

    localparam logic [1407:0] K1 = {
        128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
        128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
        128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
        128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
        128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
        128'h13111d7fe3944a17f307a78b4d2b30c5};
    localparam logic [1407:0] K2 = {
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] R1 = 128'ha49c7ff2689f352b6b5bea43026a5049;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Returns after the start edge T, at T+1ns.
    task automatic start_one(input logic [127:0] pt, input logic [1407:0] rk);
        @(negedge clk);
        bus.plaintext = pt;
        bus.rkeys     = rk;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Counts edges after T (already_seen of them have elapsed); lat=-1 on timeout.
    task automatic wait_done(input int already_seen, output int lat);
        lat = -1;
        for (int n = already_seen + 1; n <= 30; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int first_lat;
        int d_at [0:3];
        logic [127:0] first_ct;
        logic [1407:0] rnd_keys;

        bus.start     = 1'b0;
        bus.plaintext = '0;
        bus.rkeys     = '0;

        #2;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ct", bus.ciphertext, 0);
        chk("rst_st", dut.st_q, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // FIPS-197 C.1
        start_one(P1, K1);
        chk("v1_busy", bus.busy, 1);
        wait_done(0, lat);
        chk("v1_latency", lat, 10);
        chk("v1_ct", bus.ciphertext, C1);
        chk("v1_busy_at_done", bus.busy, 0);
        $display("v1: ct=%h latency=%0d", bus.ciphertext, lat);
        @(posedge clk);
        #1;
        chk("v1_done_single", bus.done, 0);

        // FIPS-197 Appendix B
        start_one(P2, K2);
        @(posedge clk);
        #1;
        chk("v2_round1_st", dut.st_q, R1);
        chk("v2_ct_hold_run", bus.ciphertext, C1);
        wait_done(1, lat);
        chk("v2_latency", lat, 10);
        chk("v2_ct", bus.ciphertext, C2);
        $display("v2: ct=%h latency=%0d", bus.ciphertext, lat);

        // start re-asserted mid-run must be ignored
        start_one(P1, K1);
        pulses    = 0;
        first_lat = -1;
        first_ct  = '0;
        for (int n = 1; n <= 25; n++) begin
            @(negedge clk);
            bus.start     = (n >= 3 && n <= 8);
            bus.plaintext = (n >= 3 && n <= 8) ? P2 : P1;
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                if (first_lat < 0) begin
                    first_lat = n;
                    first_ct  = bus.ciphertext;
                end
            end
        end
        bus.start = 1'b0;
        chk("busy_start_pulses", pulses, 1);
        chk("busy_start_latency", first_lat, 10);
        chk("busy_start_ct", first_ct, C1);
        chk("busy_start_ct_end", bus.ciphertext, C1);
        $display("busy-start: ct=%h pulses=%0d latency=%0d", first_ct, pulses, first_lat);

        // back-to-back with start held high
        @(negedge clk);
        bus.plaintext = P1;
        bus.rkeys     = K1;
        bus.start     = 1'b1;
        pulses = 0;
        for (int k = 0; k <= 34; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                if (pulses < 4) d_at[pulses] = k;
                pulses++;
                chk("b2b_ct", bus.ciphertext, C1);
                $display("b2b: ct=%h at edge %0d", bus.ciphertext, k);
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        chk("b2b_pulses", pulses, 3);
        chk("b2b_done0", d_at[0], 10);
        chk("b2b_done1", d_at[1], 21);
        chk("b2b_done2", d_at[2], 32);
        wait_done(0, lat);
        chk("b2b_tail_done_seen", (lat > 0), 1);
        chk("b2b_tail_ct", bus.ciphertext, C1);

        // asynchronous reset in round 5
        start_one(P2, K2);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_mid_rnd", dut.rnd_q, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", bus.busy, 0);
        chk("rst_mid_done", bus.done, 0);
        chk("rst_mid_ct", bus.ciphertext, 0);
        chk("rst_mid_rnd0", dut.rnd_q, 0);
        for (int n = 0; n < 3; n++) begin
            @(posedge clk);
            #1;
            chk("rst_hold_done", bus.done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start_one(P2, K2);
        wait_done(0, lat);
        chk("post_rst_latency", lat, 10);
        chk("post_rst_ct", bus.ciphertext, C2);
        $display("post-reset: ct=%h latency=%0d", bus.ciphertext, lat);

        // idle hold with inputs churning
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            for (int w = 0; w < 44; w++) rnd_keys[w*32 +: 32] = $urandom();
            bus.rkeys     = rnd_keys;
            bus.plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            chk("idle_ct", bus.ciphertext, C2);
            chk("idle_busy", bus.busy, 0);
            chk("idle_done", bus.done, 0);
        end
        $display("idle-hold: ct=%h after 50 cycles", bus.ciphertext);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
